stream_mux_n_to_1: RTL and testbench

STREAM_MUX_N_TO_1 -- requirements
Module: stream_mux_n_to_1

---
 rtl/stream_mux_pkg.sv | 15 +
 rtl/rr_arbiter.sv | 30 +++
 rtl/stream_mux_n_to_1.sv | 176 +++++++++++++++++
 tb/tb_stream_mux_n_to_1.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/stream_mux_pkg.sv
// Shared types and constants for the N-to-1 packet-aware stream multiplexer.
// The round-robin mode is present only when STREAM_MUX_RR_EN is defined.
package stream_mux_pkg;

    // Arbitration FSM: IDLE arbitrates per packet, LOCKED holds one channel until its last beat.
    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } state_e;

    // Values of the mode input.
    localparam logic MODE_FIXED = 1'b0;
    localparam logic MODE_RR    = 1'b1;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin search: grants the first requesting channel above ptr, wrapping modulo N.
module rr_arbiter #(
    parameter int unsigned N     = 4,
    parameter int unsigned SEL_W = 2
) (
    input  logic [N-1:0]     req,
    input  logic [SEL_W-1:0] ptr,
    output logic [SEL_W-1:0] grant,
    output logic             grant_vld
);

    // Two passes: first the channels strictly above ptr, then wrap to the lowest requester.
    always_comb begin
        grant     = '0;
        grant_vld = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (!grant_vld && req[i] && (SEL_W'(i) > ptr)) begin
                grant     = SEL_W'(i);
                grant_vld = 1'b1;
            end
        end
        for (int i = 0; i < N; i++) begin
            if (!grant_vld && req[i]) begin
                grant     = SEL_W'(i);
                grant_vld = 1'b1;
            end
        end
    end

endmodule

// File: rtl/stream_mux_n_to_1.sv
// N-to-1 stream multiplexer with packet locking and a registered output stage.
// Define STREAM_MUX_RR_EN to build in round-robin arbitration (mode = 1);
// without it the block is fixed-select only and mode is ignored.
module stream_mux_n_to_1
    import stream_mux_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned N     = 4,
    localparam int unsigned SEL_W = ($clog2(N) > 1) ? $clog2(N) : 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N*WIDTH-1:0]   in_data,
    input  logic [N-1:0]         in_valid,
    input  logic [N-1:0]         in_last,
    output logic [N-1:0]         in_ready,
    input  logic [SEL_W-1:0]     select,
    input  logic                 mode,
    output logic [WIDTH-1:0]     out_data,
    output logic                 out_valid,
    output logic                 out_last,
    output logic [SEL_W-1:0]     out_ch,
    input  logic                 out_ready
);

    state_e             state_q, state_d;
    logic [SEL_W-1:0]   lock_ch_q, lock_ch_d;
    logic [WIDTH-1:0]   out_data_q, out_data_d;
    logic               out_valid_q, out_valid_d;
    logic               out_last_q, out_last_d;
    logic [SEL_W-1:0]   out_ch_q, out_ch_d;

    logic [SEL_W-1:0]   grant;
    logic               grant_vld;
    logic [WIDTH-1:0]   sel_data;
    logic               sel_valid;
    logic               sel_last;
    logic               can_accept;
    logic               transfer;

`ifdef STREAM_MUX_RR_EN
    logic [SEL_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [SEL_W-1:0]   rr_grant;
    logic               rr_grant_vld;

    rr_arbiter #(
        .N     (N),
        .SEL_W (SEL_W)
    ) u_rr_arbiter (
        .req       (in_valid),
        .ptr       (rr_ptr_q),
        .grant     (rr_grant),
        .grant_vld (rr_grant_vld)
    );
`else
    logic unused_mode;
    assign unused_mode = mode;
`endif

    assign can_accept = !out_valid_q || out_ready;

    // Grant selection: the locked channel wins; otherwise fixed select or round-robin.
    always_comb begin
        grant     = lock_ch_q;
        grant_vld = 1'b1;
        if (state_q == IDLE) begin
`ifdef STREAM_MUX_RR_EN
            if (mode == MODE_RR) begin
                grant     = rr_grant;
                grant_vld = rr_grant_vld;
            end else begin
                grant     = select;
                grant_vld = (32'(select) < N);
            end
`else
            grant     = select;
            grant_vld = (32'(select) < N);
`endif
        end
        // No handshake may complete while reset is held.
        if (!rst_n) begin
            grant_vld = 1'b0;
        end
    end

    // Steer the granted channel onto the internal beat bus and raise its ready.
    always_comb begin
        sel_data  = '0;
        sel_valid = 1'b0;
        sel_last  = 1'b0;
        in_ready  = '0;
        for (int i = 0; i < N; i++) begin
            if (grant_vld && (grant == SEL_W'(i))) begin
                sel_data    = in_data[i*WIDTH +: WIDTH];
                sel_valid   = in_valid[i];
                sel_last    = in_last[i];
                in_ready[i] = can_accept;
            end
        end
    end

    assign transfer = sel_valid && can_accept;

    // Output register, FSM and round-robin pointer next-state.
    always_comb begin
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
        out_ch_d    = out_ch_q;
        state_d     = state_q;
        lock_ch_d   = lock_ch_q;
`ifdef STREAM_MUX_RR_EN
        rr_ptr_d    = rr_ptr_q;
`endif
        if (transfer) begin
            out_data_d  = sel_data;
            out_valid_d = 1'b1;
            out_last_d  = sel_last;
            out_ch_d    = grant;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end

        unique case (state_q)
            IDLE: begin
                if (transfer && !sel_last) begin
                    state_d   = LOCKED;
                    lock_ch_d = grant;
                end
            end
            LOCKED: begin
                if (transfer && sel_last) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

`ifdef STREAM_MUX_RR_EN
        if (transfer && sel_last) begin
            rr_ptr_d = grant;
        end
`endif
    end

    // State registers; rr_ptr resets to N-1 so channel 0 has first priority.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            lock_ch_q   <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_ch_q    <= '0;
`ifdef STREAM_MUX_RR_EN
            rr_ptr_q    <= SEL_W'(N - 1);
`endif
        end else begin
            state_q     <= state_d;
            lock_ch_q   <= lock_ch_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            out_ch_q    <= out_ch_d;
`ifdef STREAM_MUX_RR_EN
            rr_ptr_q    <= rr_ptr_d;
`endif
        end
    end

    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign out_last  = out_last_q;
    assign out_ch    = out_ch_q;

endmodule

// File: tb/tb_stream_mux_n_to_1.sv
// Directed bench for stream_mux_n_to_1: a default N=4 instance plus an N=5 instance
// used for the out-of-range select case.
module tb_stream_mux_n_to_1;

    logic        clk;
    logic        rst_n;

    // N = 4 instance
    logic [31:0] in_data;
    logic [3:0]  in_valid;
    logic [3:0]  in_last;
    logic [3:0]  in_ready;
    logic [1:0]  select;
    logic        mode;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_last;
    logic [1:0]  out_ch;
    logic        out_ready;

    // N = 5 instance
    logic [39:0] in_data5;
    logic [4:0]  in_valid5;
    logic [4:0]  in_last5;
    logic [4:0]  in_ready5;
    logic [2:0]  select5;
    logic [7:0]  out_data5;
    logic        out_valid5;
    logic        out_last5;
    logic [2:0]  out_ch5;

    int n_tests;
    int n_fail;

    stream_mux_n_to_1 #(.WIDTH(8), .N(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_last   (in_last),
        .in_ready  (in_ready),
        .select    (select),
        .mode      (mode),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_last  (out_last),
        .out_ch    (out_ch),
        .out_ready (out_ready)
    );

    stream_mux_n_to_1 #(.WIDTH(8), .N(5)) dut5 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data5),
        .in_valid  (in_valid5),
        .in_last   (in_last5),
        .in_ready  (in_ready5),
        .select    (select5),
        .mode      (1'b0),
        .out_data  (out_data5),
        .out_valid (out_valid5),
        .out_last  (out_last5),
        .out_ch    (out_ch5),
        .out_ready (1'b1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic put(input int ch, input logic [7:0] d, input logic l);
        in_data[ch*8 +: 8] = d;
        in_last[ch]        = l;
        in_valid[ch]       = 1'b1;
    endtask

    initial begin
        n_tests   = 0;
        n_fail    = 0;
        rst_n     = 1'b0;
        in_data   = '0;
        in_valid  = '0;
        in_last   = '0;
        select    = 2'd0;
        mode      = 1'b0;
        out_ready = 1'b1;
        in_data5  = '0;
        in_valid5 = '0;
        in_last5  = '1;
        select5   = 3'd0;

        // Reset values, with a valid request pending on the selected channel
        in_valid = 4'b0001;
        #3;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data",  32'(out_data),  32'd0);
        check("rst_out_last",  32'(out_last),  32'd0);
        check("rst_out_ch",    32'(out_ch),    32'd0);
        check("rst_in_ready",  32'(in_ready),  32'd0);
        in_valid = '0;
        cycle();
        rst_n = 1'b1;
        #1;

        // Out-of-range select on N=5 never grants
        select5   = 3'd5;
        in_valid5 = 5'b11111;
        #1;
        check("sel5_in_ready", 32'(in_ready5), 32'd0);
        for (int k = 0; k < 3; k++) begin
            cycle();
            check("sel5_out_valid", 32'(out_valid5), 32'd0);
        end
        select5 = 3'd7;
        #1;
        check("sel7_in_ready", 32'(in_ready5), 32'd0);
        cycle();
        check("sel7_out_valid", 32'(out_valid5), 32'd0);
        // Highest legal index still grants
        select5 = 3'd4;
        in_data5[39:32] = 8'h44;
        #1;
        check("sel4_in_ready", 32'(in_ready5), 32'h10);
        cycle();
        check("sel4_out_ch",   32'(out_ch5),   32'd4);
        check("sel4_out_data", 32'(out_data5), 32'h44);
        in_valid5 = '0;

        // Fixed mode, ch2 three-beat packet
        mode   = 1'b0;
        select = 2'd2;
        put(2, 8'hA1, 1'b0);
        #1;
        check("fx_in_ready", 32'(in_ready), 32'b0100);
        cycle();
        check("fx_b1_valid", 32'(out_valid), 32'd1);
        check("fx_b1_data",  32'(out_data),  32'hA1);
        check("fx_b1_ch",    32'(out_ch),    32'd2);
        check("fx_b1_last",  32'(out_last),  32'd0);
        put(2, 8'hA2, 1'b0);
        cycle();
        check("fx_b2_data",  32'(out_data),  32'hA2);
        check("fx_b2_last",  32'(out_last),  32'd0);
        put(2, 8'hA3, 1'b1);
        cycle();
        check("fx_b3_data",  32'(out_data),  32'hA3);
        check("fx_b3_last",  32'(out_last),  32'd1);
        check("fx_b3_ch",    32'(out_ch),    32'd2);
        in_valid = '0;
        cycle();
        check("fx_drain_valid", 32'(out_valid), 32'd0);

        // Select changes mid-packet: ch2 finishes before ch0 is served
        select = 2'd2;
        put(2, 8'hA1, 1'b0);
        put(0, 8'hB1, 1'b1);
        cycle();
        check("sw_b1_ch", 32'(out_ch), 32'd2);
        select = 2'd0;
        put(2, 8'hA2, 1'b0);
        #1;
        check("sw_locked_ready", 32'(in_ready), 32'b0100);
        cycle();
        check("sw_b2_ch",   32'(out_ch),   32'd2);
        check("sw_b2_data", 32'(out_data), 32'hA2);
        put(2, 8'hA3, 1'b1);
        cycle();
        check("sw_b3_ch",   32'(out_ch),   32'd2);
        check("sw_b3_data", 32'(out_data), 32'hA3);
        in_valid[2] = 1'b0;
        #1;
        check("sw_idle_ready", 32'(in_ready), 32'b0001);
        cycle();
        check("sw_ch0_ch",   32'(out_ch),   32'd0);
        check("sw_ch0_data", 32'(out_data), 32'hB1);
        in_valid = '0;
        cycle();

        // Downstream stall for 5 cycles mid-packet
        select = 2'd1;
        put(1, 8'hC1, 1'b0);
        cycle();
        check("st_c1_data", 32'(out_data), 32'hC1);
        put(1, 8'hC2, 1'b0);
        out_ready = 1'b0;
        #1;
        check("st_ready0", 32'(in_ready), 32'd0);
        for (int k = 0; k < 5; k++) begin
            cycle();
            check("st_hold_data",  32'(out_data),  32'hC1);
            check("st_hold_valid", 32'(out_valid), 32'd1);
            check("st_hold_ready", 32'(in_ready),  32'd0);
        end
        out_ready = 1'b1;
        #1;
        check("st_resume_ready", 32'(in_ready), 32'b0010);
        cycle();
        check("st_c2_data", 32'(out_data), 32'hC2);
        put(1, 8'hC3, 1'b1);
        cycle();
        check("st_c3_data", 32'(out_data), 32'hC3);
        check("st_c3_last", 32'(out_last), 32'd1);
        in_valid = '0;
        cycle();
        check("st_drain_valid", 32'(out_valid), 32'd0);

        // Reset during beat 2 of a ch1 packet, then fresh arbitration
        mode   = 1'b1;
        select = 2'd1;
        put(1, 8'hD1, 1'b0);
        cycle();
        check("rp_d1_ch", 32'(out_ch), 32'd1);
        put(1, 8'hD2, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check("rp_out_valid", 32'(out_valid), 32'd0);
        check("rp_in_ready",  32'(in_ready),  32'd0);
        for (int i = 0; i < 4; i++) put(i, 8'h10 + 8'(i), 1'b1);
        select = 2'd0;
        cycle();
        rst_n = 1'b1;
        #1;
        check("rp_first_ready", 32'(in_ready), 32'b0001);
        // Continuous single-beat packets on all channels
        for (int k = 0; k < 6; k++) begin
            int exp_ch;
`ifdef STREAM_MUX_RR_EN
            exp_ch = k % 4;
`else
            exp_ch = 0;
`endif
            cycle();
            check("rr_out_ch",   32'(out_ch),   32'(exp_ch));
            check("rr_out_data", 32'(out_data), 32'h10 + 32'(exp_ch));
            check("rr_out_last", 32'(out_last), 32'd1);
        end
        in_valid = '0;
        cycle();
        check("end_valid", 32'(out_valid), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
